// File: rtl/sci_bus_arbiter_pkg.sv
// Shared constants and types for the SCI register-port arbiter.
package sci_pkg;

   localparam logic [31:0] SCITX   = 32'h0000_0000;
   localparam logic [31:0] SCIRX   = 32'h0000_0004;
   localparam logic [31:0] SCICFG  = 32'h0000_0008;
   localparam logic [31:0] SCIFLAG = 32'h0000_000C;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } arb_state_e;

endpackage

// File: rtl/sci_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant; on a tie (or no request) the master other than last_grant wins.
module sci_rr_arb2
   import sci_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_update,
   output logic o_gnt
);

   logic r_last_grant;

   always_comb begin
      if (i_req0 && !i_req1) begin
         o_gnt = M0;
      end else if (i_req1 && !i_req0) begin
         o_gnt = M1;
      end else begin
         o_gnt = ~r_last_grant;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_last_grant <= M1;
      end else if (i_update) begin
         r_last_grant <= o_gnt;
      end
   end

endmodule

// File: rtl/sci_bus_arbiter.sv
// Shares the SCI register port between M0 and M1: one request in flight, routed read
// response with timeout, and bounded stalling of SCITX writes while the TX FIFO is full.
module sci_bus_arbiter
   import sci_pkg::*;
#(
   parameter int unsigned RD_TIMEOUT   = 4,
   parameter int unsigned TX_STALL_MAX = 1023
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iM0_REQ_VALID,
   output logic        oM0_REQ_BUSY,
   input  logic        iM0_REQ_RW,
   input  logic [31:0] iM0_REQ_ADDR,
   input  logic [31:0] iM0_REQ_DATA,
   output logic        oM0_RD_VALID,
   output logic [31:0] oM0_RD_DATA,
   input  logic        iM1_REQ_VALID,
   output logic        oM1_REQ_BUSY,
   input  logic        iM1_REQ_RW,
   input  logic [31:0] iM1_REQ_ADDR,
   input  logic [31:0] iM1_REQ_DATA,
   output logic        oM1_RD_VALID,
   output logic [31:0] oM1_RD_DATA,
   output logic        oSCI_REQ_VALID,
   input  logic        iSCI_REQ_BUSY,
   output logic        oSCI_REQ_RW,
   output logic [31:0] oSCI_REQ_ADDR,
   output logic [31:0] oSCI_REQ_DATA,
   input  logic        iSCI_REQ_VALID,
   input  logic [31:0] iSCI_REQ_DATA,
   output logic        oTX_DROP
);

   localparam logic [3:0] TOUT_LAST  = 4'(RD_TIMEOUT - 1);
   localparam logic [9:0] STALL_LAST = 10'(TX_STALL_MAX);

   arb_state_e  r_state;
   logic        r_owner;
   logic        r_rw;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [9:0]  r_stall_cnt;
   logic [3:0]  r_tout_cnt;
   logic [31:0] r_m0_rd_data;
   logic [31:0] r_m1_rd_data;

   logic        w_gnt;
   logic        w_accept;
   logic        w_tx_stall;
   logic        w_drop;
   logic        w_rd_done;
   logic [31:0] w_rd_data;

   sci_rr_arb2 u_rr_arb2 (
      .i_clk    (iCLOCK),
      .i_rst_n  (inRESET),
      .i_req0   (iM0_REQ_VALID),
      .i_req1   (iM1_REQ_VALID),
      .i_update (w_accept),
      .o_gnt    (w_gnt)
   );

   assign w_accept   = (r_state == StIdle) && ((w_gnt == M0) ? iM0_REQ_VALID : iM1_REQ_VALID);
   assign w_tx_stall = (r_state == StIssue) && r_rw && (r_addr == SCITX) && iSCI_REQ_BUSY;
   assign w_drop     = w_tx_stall && (r_stall_cnt == STALL_LAST);
   assign w_rd_done  = (r_state == StWait) && (iSCI_REQ_VALID || (r_tout_cnt == TOUT_LAST));
   // A missing acknowledge completes the read with zero data.
   assign w_rd_data  = iSCI_REQ_VALID ? iSCI_REQ_DATA : 32'h0;

   assign oM0_REQ_BUSY = !((r_state == StIdle) && (w_gnt == M0));
   assign oM1_REQ_BUSY = !((r_state == StIdle) && (w_gnt == M1));

   // Gating by inRESET keeps an abandoned request from producing any pulse.
   assign oSCI_REQ_VALID = inRESET && (r_state == StIssue) && !w_tx_stall;
   assign oSCI_REQ_RW    = r_rw;
   assign oSCI_REQ_ADDR  = r_addr;
   assign oSCI_REQ_DATA  = r_data;
   assign oTX_DROP       = inRESET && w_drop;

   assign oM0_RD_VALID = inRESET && w_rd_done && (r_owner == M0);
   assign oM1_RD_VALID = inRESET && w_rd_done && (r_owner == M1);
   assign oM0_RD_DATA  = oM0_RD_VALID ? w_rd_data : r_m0_rd_data;
   assign oM1_RD_DATA  = oM1_RD_VALID ? w_rd_data : r_m1_rd_data;

   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         r_state      <= StIdle;
         r_owner      <= M0;
         r_rw         <= 1'b0;
         r_addr       <= 32'h0;
         r_data       <= 32'h0;
         r_stall_cnt  <= 10'h0;
         r_tout_cnt   <= 4'h0;
         r_m0_rd_data <= 32'h0;
         r_m1_rd_data <= 32'h0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_owner     <= w_gnt;
                  r_rw        <= (w_gnt == M0) ? iM0_REQ_RW   : iM1_REQ_RW;
                  r_addr      <= (w_gnt == M0) ? iM0_REQ_ADDR : iM1_REQ_ADDR;
                  r_data      <= (w_gnt == M0) ? iM0_REQ_DATA : iM1_REQ_DATA;
                  r_stall_cnt <= 10'h0;
                  r_state     <= StIssue;
               end
            end
            StIssue: begin
               if (w_drop) begin
                  r_state <= StIdle;
               end else if (w_tx_stall) begin
                  r_stall_cnt <= r_stall_cnt + 10'h1;
               end else begin
                  r_tout_cnt <= 4'h0;
                  r_state    <= r_rw ? StIdle : StWait;
               end
            end
            StWait: begin
               if (w_rd_done) begin
                  if (r_owner == M0) begin
                     r_m0_rd_data <= w_rd_data;
                  end else begin
                     r_m1_rd_data <= w_rd_data;
                  end
                  r_state <= StIdle;
               end else begin
                  r_tout_cnt <= r_tout_cnt + 4'h1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sci_bus_arbiter.sv
// Directed bench: queued expectations for SCI requests and read responses, plus
// cycle-exact checks; a second instance with TX_STALL_MAX=8 covers the drop path.
module tb_sci_bus_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_valid, m0_rw, m1_valid, m1_rw;
   logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
   logic        sci_busy, sci_ack;
   logic [31:0] sci_rdata;

   logic        m0_busy, m1_busy, m0_rd_valid, m1_rd_valid;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic        sci_valid, sci_rw, tx_drop;
   logic [31:0] sci_addr, sci_wdata;

   logic        d8_m0_busy, d8_m1_busy, d8_m0_rd_valid, d8_m1_rd_valid;
   logic [31:0] d8_m0_rd_data, d8_m1_rd_data;
   logic        d8_sci_valid, d8_sci_rw, d8_tx_drop;
   logic [31:0] d8_sci_addr, d8_sci_wdata;

   int n_checks = 0;
   int n_errors = 0;

   logic [64:0] sci_q[$];
   logic [32:0] rd_q[$];

   sci_bus_arbiter u_dut (
      .iCLOCK         (clk),
      .inRESET        (rst_n),
      .iM0_REQ_VALID  (m0_valid),
      .oM0_REQ_BUSY   (m0_busy),
      .iM0_REQ_RW     (m0_rw),
      .iM0_REQ_ADDR   (m0_addr),
      .iM0_REQ_DATA   (m0_data),
      .oM0_RD_VALID   (m0_rd_valid),
      .oM0_RD_DATA    (m0_rd_data),
      .iM1_REQ_VALID  (m1_valid),
      .oM1_REQ_BUSY   (m1_busy),
      .iM1_REQ_RW     (m1_rw),
      .iM1_REQ_ADDR   (m1_addr),
      .iM1_REQ_DATA   (m1_data),
      .oM1_RD_VALID   (m1_rd_valid),
      .oM1_RD_DATA    (m1_rd_data),
      .oSCI_REQ_VALID (sci_valid),
      .iSCI_REQ_BUSY  (sci_busy),
      .oSCI_REQ_RW    (sci_rw),
      .oSCI_REQ_ADDR  (sci_addr),
      .oSCI_REQ_DATA  (sci_wdata),
      .iSCI_REQ_VALID (sci_ack),
      .iSCI_REQ_DATA  (sci_rdata),
      .oTX_DROP       (tx_drop)
   );

   sci_bus_arbiter #(
      .RD_TIMEOUT   (4),
      .TX_STALL_MAX (8)
   ) u_dut8 (
      .iCLOCK         (clk),
      .inRESET        (rst_n),
      .iM0_REQ_VALID  (m0_valid),
      .oM0_REQ_BUSY   (d8_m0_busy),
      .iM0_REQ_RW     (m0_rw),
      .iM0_REQ_ADDR   (m0_addr),
      .iM0_REQ_DATA   (m0_data),
      .oM0_RD_VALID   (d8_m0_rd_valid),
      .oM0_RD_DATA    (d8_m0_rd_data),
      .iM1_REQ_VALID  (m1_valid),
      .oM1_REQ_BUSY   (d8_m1_busy),
      .iM1_REQ_RW     (m1_rw),
      .iM1_REQ_ADDR   (m1_addr),
      .iM1_REQ_DATA   (m1_data),
      .oM1_RD_VALID   (d8_m1_rd_valid),
      .oM1_RD_DATA    (d8_m1_rd_data),
      .oSCI_REQ_VALID (d8_sci_valid),
      .iSCI_REQ_BUSY  (sci_busy),
      .oSCI_REQ_RW    (d8_sci_rw),
      .oSCI_REQ_ADDR  (d8_sci_addr),
      .oSCI_REQ_DATA  (d8_sci_wdata),
      .iSCI_REQ_VALID (sci_ack),
      .iSCI_REQ_DATA  (sci_rdata),
      .oTX_DROP       (d8_tx_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      m0_valid = 1'b0; m0_rw = 1'b0; m0_addr = 32'h0; m0_data = 32'h0;
      m1_valid = 1'b0; m1_rw = 1'b0; m1_addr = 32'h0; m1_data = 32'h0;
      sci_busy = 1'b0; sci_ack = 1'b0; sci_rdata = 32'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Scoreboard: every SCI request and every read response must match the queue head.
   always @(negedge clk) begin
      if (sci_valid === 1'b1) begin
         if (sci_q.size() == 0) chk("sci_unexpected", {71'h0, sci_valid}, 72'h0);
         else chk("sci_req", {sci_rw, sci_addr, sci_wdata}, sci_q.pop_front());
      end
      if (m0_rd_valid === 1'b1) begin
         if (rd_q.size() == 0) chk("m0_rd_unexpected", {71'h0, m0_rd_valid}, 72'h0);
         else chk("m0_rd_route", {1'b0, m0_rd_data}, rd_q.pop_front());
      end
      if (m1_rd_valid === 1'b1) begin
         if (rd_q.size() == 0) chk("m1_rd_unexpected", {71'h0, m1_rd_valid}, 72'h0);
         else chk("m1_rd_route", {1'b1, m1_rd_data}, rd_q.pop_front());
      end
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();

      // Reset state
      do_reset();
      smp();
      chk("rst_sci_valid", sci_valid, 1'b0);
      chk("rst_m0_rd_valid", m0_rd_valid, 1'b0);
      chk("rst_m1_rd_valid", m1_rd_valid, 1'b0);
      chk("rst_m0_rd_data", m0_rd_data, 32'h0);
      chk("rst_m1_rd_data", m1_rd_data, 32'h0);
      chk("rst_tx_drop", tx_drop, 1'b0);
      chk("rst_m0_busy", m0_busy, 1'b0);
      chk("rst_m1_busy", m1_busy, 1'b1);

      // M0 writes SCICFG
      nxt();
      m0_valid = 1'b1; m0_rw = 1'b1; m0_addr = 32'h8; m0_data = 32'h0000_0243;
      sci_q.push_back({1'b1, 32'h8, 32'h0000_0243});
      smp();
      chk("wr_accept_m0_busy", m0_busy, 1'b0);
      chk("wr_accept_m1_busy", m1_busy, 1'b1);
      chk("wr_accept_no_sci", sci_valid, 1'b0);
      nxt();
      m0_valid = 1'b0;
      smp();
      chk("wr_sci_valid", sci_valid, 1'b1);
      chk("wr_issue_m1_busy", m1_busy, 1'b1);
      nxt();
      smp();
      chk("wr_one_cycle", sci_valid, 1'b0);

      // Simultaneous SCIFLAG reads after reset
      do_reset();
      m0_valid = 1'b1; m0_rw = 1'b0; m0_addr = 32'hC; m0_data = 32'h0;
      m1_valid = 1'b1; m1_rw = 1'b0; m1_addr = 32'hC; m1_data = 32'h1111;
      sci_q.push_back({1'b0, 32'hC, 32'h0});
      sci_q.push_back({1'b0, 32'hC, 32'h1111});
      smp();
      chk("tie_m0_busy", m0_busy, 1'b0);
      chk("tie_m1_busy", m1_busy, 1'b1);
      nxt();
      m0_valid = 1'b0;
      smp();
      nxt();
      sci_ack = 1'b1; sci_rdata = 32'h2;
      rd_q.push_back({1'b0, 32'h2});
      smp();
      chk("rd0_valid", m0_rd_valid, 1'b1);
      chk("rd0_data", m0_rd_data, 32'h2);
      chk("rd0_no_cross", m1_rd_valid, 1'b0);
      nxt();
      sci_ack = 1'b0; sci_rdata = 32'h0;
      smp();
      chk("rd1_grant", m1_busy, 1'b0);
      nxt();
      m1_valid = 1'b0;
      smp();
      nxt();
      sci_ack = 1'b1; sci_rdata = 32'h5;
      rd_q.push_back({1'b1, 32'h5});
      smp();
      chk("rd1_valid", m1_rd_valid, 1'b1);
      chk("rd1_no_cross", m0_rd_valid, 1'b0);
      chk("rd0_data_held", m0_rd_data, 32'h2);
      nxt();
      sci_ack = 1'b0; sci_rdata = 32'h0;
      smp();

      // M1 reads SCITX: never acknowledged, times out with zero
      nxt();
      m1_valid = 1'b1; m1_rw = 1'b0; m1_addr = 32'h0; m1_data = 32'h0;
      sci_q.push_back({1'b0, 32'h0, 32'h0});
      rd_q.push_back({1'b1, 32'h0});
      smp();
      chk("tout_grant", m1_busy, 1'b0);
      nxt();
      m1_valid = 1'b0;
      smp();
      for (int i = 0; i < 4; i++) begin
         nxt();
         smp();
         chk("tout_rd_valid", m1_rd_valid, (i == 3));
      end
      chk("tout_rd_data", m1_rd_data, 32'h0);

      // SCITX write stalled 10 cycles, then issued in the cycle busy drops
      nxt();
      sci_busy = 1'b1;
      m0_valid = 1'b1; m0_rw = 1'b1; m0_addr = 32'h0; m0_data = 32'h41;
      sci_q.push_back({1'b1, 32'h0, 32'h41});
      smp();
      chk("stall_accept", m0_busy, 1'b0);
      nxt();
      m0_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         smp();
         chk("stall_no_sci", sci_valid, 1'b0);
         chk("stall_no_drop", tx_drop, 1'b0);
         nxt();
      end
      sci_busy = 1'b0;
      smp();
      chk("stall_release_sci", sci_valid, 1'b1);
      chk("stall_release_drop", tx_drop, 1'b0);
      nxt();
      smp();

      // TX_STALL_MAX=8: dropped after 8 stall cycles
      do_reset();
      sci_busy = 1'b1;
      m0_valid = 1'b1; m0_rw = 1'b1; m0_addr = 32'h0; m0_data = 32'h55;
      sci_q.push_back({1'b1, 32'h0, 32'h55});
      smp();
      nxt();
      m0_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         smp();
         chk("d8_stall_no_sci", d8_sci_valid, 1'b0);
         chk("d8_stall_no_drop", d8_tx_drop, 1'b0);
         nxt();
      end
      smp();
      chk("d8_drop_pulse", d8_tx_drop, 1'b1);
      chk("d8_drop_no_sci", d8_sci_valid, 1'b0);
      nxt();
      m1_valid = 1'b1; m1_rw = 1'b0; m1_addr = 32'h4; m1_data = 32'h0;
      smp();
      chk("d8_drop_single", d8_tx_drop, 1'b0);
      chk("d8_m1_grant", d8_m1_busy, 1'b0);
      chk("dut_still_stalled", sci_valid, 1'b0);
      nxt();
      m1_valid = 1'b0;
      sci_busy = 1'b0;
      smp();
      chk("d8_m1_issue", {d8_sci_valid, d8_sci_rw, d8_sci_addr}, {1'b1, 1'b0, 32'h4});
      nxt();
      smp();

      // Reset during WAIT abandons the read
      nxt();
      m0_valid = 1'b1; m0_rw = 1'b0; m0_addr = 32'h4; m0_data = 32'h0;
      sci_q.push_back({1'b0, 32'h4, 32'h0});
      smp();
      nxt();
      m0_valid = 1'b0;
      smp();
      nxt();
      rst_n = 1'b0;
      sci_ack = 1'b1; sci_rdata = 32'hDEAD;
      smp();
      chk("rstw_m0_rd_valid", m0_rd_valid, 1'b0);
      chk("rstw_m1_rd_valid", m1_rd_valid, 1'b0);
      chk("rstw_tx_drop", tx_drop, 1'b0);
      nxt();
      rst_n = 1'b1;
      sci_ack = 1'b0; sci_rdata = 32'h0;
      m0_valid = 1'b1; m0_rw = 1'b1; m0_addr = 32'h8; m0_data = 32'h1;
      m1_valid = 1'b1; m1_rw = 1'b1; m1_addr = 32'h8; m1_data = 32'h2;
      sci_q.push_back({1'b1, 32'h8, 32'h1});
      sci_q.push_back({1'b1, 32'h8, 32'h2});
      smp();
      chk("rstw_m0_wins", m0_busy, 1'b0);
      chk("rstw_m1_waits", m1_busy, 1'b1);
      chk("rstw_rd_data_cleared", m0_rd_data, 32'h0);
      nxt();
      m0_valid = 1'b0;
      smp();
      nxt();
      smp();
      chk("rstw_m1_next", m1_busy, 1'b0);
      nxt();
      m1_valid = 1'b0;
      smp();
      nxt();
      smp();
      nxt();
      smp();

      chk("sci_q_drained", sci_q.size(), 0);
      chk("rd_q_drained", rd_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
